instr_fetch_unit: RTL and testbench

// - Fetch stage upstream of control_unit: owns the PC, requests instruction words from imem, presents instr to decode.
// - control_unit decodes instr_o[6:0]; Branch/BNE/JAL/JALR and the ALU zero flag return here to select the next PC.
// - Valid/ready handshake on both sides lets imem have variable latency and lets decode stall.

---
 rtl/instr_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage ahead of control_unit.
// Owns the PC, requests instruction words from imem over a req/gnt +
// rvalid handshake, holds the word for decode until it retires, then
// selects the next PC from the branch/jump controls and the ALU zero flag.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   imem_req/imem_addr/imem_gnt     fetch request channel (addr = pc_o)
//   imem_rvalid/imem_rdata          fetch response channel
//   instr_o/instr_valid/instr_ready instruction handed to decode
//   pc_o/pc_plus4_o                 PC of instr_o and its link value
//   branch/bne/jal/jalr/alu_zero    next-PC selection for instr_o
//   imm/rs1_data                    target operands
//   fetch_fault                     sticky misaligned-target flag
//
// Build option MISALIGN_TRAP_EN: a misaligned next PC halts fetch and
// raises fetch_fault. Without it the target's low two bits are cleared
// and fetch_fault is tied low.
//
// state | meaning
// IDLE  | out of reset, issue first request next cycle
// REQ   | imem_req high, waiting for imem_gnt
// WAIT  | request accepted, waiting for imem_rvalid
// HOLD  | instr_o valid, waiting for instr_ready
// HALT  | misaligned target seen, fetch stopped (trap build only)

module instr_fetch_unit #(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr_o,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  input  logic            branch,
  input  logic            bne,
  input  logic            jal,
  input  logic            jalr,
  input  logic            alu_zero,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  output logic            fetch_fault
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
`ifdef MISALIGN_TRAP_EN
  localparam logic [2:0] HALT = 3'd4;
`endif

  logic [2:0]      state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;
  logic            taken;
  logic            retire;

  assign retire = (state == HOLD) && instr_ready;
  assign taken  = jal | (branch & alu_zero) | (bne & ~alu_zero);

  always_comb begin
    target = pc + XLEN'(4);
    if (jalr)
      target = (rs1_data + imm) & ~XLEN'(1);
    else if (taken)
      target = pc + imm;
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  logic fault_q;

  assign misalign = |target[1:0];
  assign next_pc  = target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fault_q <= 1'b0;
    else if (retire && misalign)
      fault_q <= 1'b1;
  end

  assign fetch_fault = fault_q;
`else
  // Misaligned targets are silently word-aligned.
  assign next_pc     = target & ~XLEN'(3);
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      instr_q <= '0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ:  if (imem_gnt) state <= WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            instr_q <= imem_rdata;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
`ifdef MISALIGN_TRAP_EN
            if (misalign) begin
              state <= HALT;
            end else begin
              pc    <= next_pc;
              state <= REQ;
            end
`else
            pc    <= next_pc;
            state <= REQ;
`endif
          end
        end
`ifdef MISALIGN_TRAP_EN
        HALT: state <= HALT;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign pc_o        = pc;
  assign pc_plus4_o  = pc + XLEN'(4);
  assign instr_o     = instr_q;
  assign instr_valid = (state == HOLD);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a transaction-level model (expected PC,
// outstanding-request / holding flags, last returned word) is checked
// against the DUT every cycle, plus directed scenarios with literal
// expectations and a randomized phase.

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr_o;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        branch = 1'b0, bne = 1'b0, jal = 1'b0, jalr = 1'b0, alu_zero = 1'b0;
  logic [31:0] imm = '0;
  logic [31:0] rs1_data = '0;
  logic        fetch_fault;

  always #5 clk = ~clk;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_o(instr_o), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .branch(branch), .bne(bne), .jal(jal), .jalr(jalr), .alu_zero(alu_zero),
    .imm(imm), .rs1_data(rs1_data), .fetch_fault(fetch_fault)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: where the fetch stream is, expressed as transaction flags.
  logic [31:0] m_pc, m_instr;
  bit          m_idle, m_req, m_wait, m_hold, m_fault;

  logic [31:0] fetch_q[$];
  int          valid_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = '0;
    m_idle = 1; m_req = 0; m_wait = 0; m_hold = 0; m_fault = 0;
  endtask

  function automatic logic [31:0] ref_target();
    if (jalr) return (rs1_data + imm) & 32'hFFFF_FFFE;
    if (jal || (branch && alu_zero) || (bne && !alu_zero)) return m_pc + imm;
    return m_pc + 32'd4;
  endfunction

  // Called at a negedge with inputs already set for the coming rising edge.
  task automatic tick();
    logic [31:0] t;
    #1;
    if (!rst_n) model_reset();
    chk("imem_req", imem_req, m_req);
    chk("instr_valid", instr_valid, m_hold);
    chk("pc_o", pc_o, m_pc);
    chk("pc_plus4_o", pc_plus4_o, m_pc + 32'd4);
    if (m_req) chk("imem_addr", imem_addr, m_pc);
    chk("instr_o", instr_o, m_instr);
    chk("fetch_fault", fetch_fault, m_fault);
    if (imem_req && imem_gnt) fetch_q.push_back(imem_addr);
    if (instr_valid) valid_cyc.push_back(cyc);
    if (rst_n) begin
      if (m_idle) begin
        m_idle = 0; m_req = 1;
      end else if (m_req) begin
        if (imem_gnt) begin m_req = 0; m_wait = 1; end
      end else if (m_wait) begin
        if (imem_rvalid) begin m_wait = 0; m_hold = 1; m_instr = imem_rdata; end
      end else if (m_hold && instr_ready) begin
        t = ref_target();
        m_hold = 0;
`ifdef MISALIGN_TRAP_EN
        if (t[1:0] != 2'b00) m_fault = 1;
        else begin m_pc = t; m_req = 1; end
`else
        m_pc = {t[31:2], 2'b00};
        m_req = 1;
`endif
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_ctrl();
    branch = 0; bne = 0; jal = 0; jalr = 0; alu_zero = 0; imm = '0; rs1_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic run_until_hold();
    int n = 0;
    while (!instr_valid && n < 40) begin tick(); n++; end
    chk("reach_hold", instr_valid, 1);
  endtask

  task automatic jump_to(input logic [31:0] tgt);
    run_until_hold();
    jal = 1; imm = tgt - pc_o;
    tick();
    clear_ctrl();
    run_until_hold();
    chk("jump_pc", pc_o, tgt);
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // Reset values and back-to-back fetch loop.
    imem_gnt = 1; imem_rvalid = 1; instr_ready = 1; imem_rdata = 32'h0000_0033;
    clear_ctrl();
    rst_n = 0;
    tick(); tick();
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_fault", fetch_fault, 0);
    rst_n = 1;
    fetch_q.delete(); valid_cyc.delete();
    repeat (10) tick();
    chk("loop_nfetch_ok", 32'(fetch_q.size() >= 3), 1);
    chk("loop_addr0", fetch_q[0], 32'h0);
    chk("loop_addr1", fetch_q[1], 32'h4);
    chk("loop_addr2", fetch_q[2], 32'h8);
    chk("loop_nvalid_ok", 32'(valid_cyc.size() >= 3), 1);
    chk("loop_spacing1", valid_cyc[1] - valid_cyc[0], 3);
    chk("loop_spacing2", valid_cyc[2] - valid_cyc[1], 3);
    chk("loop_instr", instr_o, 32'h0000_0033);

    // Branch taken / not taken from pc 0x10.
    for (int z = 1; z >= 0; z--) begin
      do_reset();
      jump_to(32'h10);
      branch = 1; alu_zero = z[0]; imm = 32'h20;
      fetch_q.delete();
      tick();
      clear_ctrl();
      run_until_hold();
      chk(z ? "beq_taken_addr" : "beq_fall_addr", fetch_q[0], z ? 32'h30 : 32'h14);
    end

    // JALR from pc 0x40, then decode stall.
    do_reset();
    jump_to(32'h40);
    chk("link_value", pc_plus4_o, 32'h44);
    jalr = 1; rs1_data = 32'h101; imm = 32'h4;
    fetch_q.delete();
    imem_rdata = 32'hABCD_0013;
    tick();
    clear_ctrl();
    run_until_hold();
    chk("jalr_addr", fetch_q[0], 32'h104);
    instr_ready = 0;
    fetch_q.delete();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_instr", instr_o, 32'hABCD_0013);
      chk("stall_pc", pc_o, 32'h104);
      chk("stall_req", imem_req, 0);
    end
    chk("stall_nfetch", fetch_q.size(), 0);
    instr_ready = 1;
    tick();
    run_until_hold();
    chk("after_stall_addr", fetch_q[0], 32'h108);

    // Reset during WAIT, stale rvalid afterwards.
    imem_rvalid = 0; imem_gnt = 1;
    while (!imem_req && cyc < 2000) tick();
    tick();
    rst_n = 0;
    tick();
    rst_n = 1; imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    repeat (3) tick();
    chk("stale_valid", instr_valid, 0);
    chk("stale_req", imem_req, 1);
    chk("stale_addr", imem_addr, 32'h0);
    chk("stale_instr", instr_o, 32'h0);
    fetch_q.delete();
    imem_gnt = 1; imem_rdata = 32'h0000_0033;
    run_until_hold();
    chk("post_rst_addr", fetch_q[0], 32'h0);

    // Misaligned JAL target from pc 0x8.
    do_reset();
    jump_to(32'h8);
    jal = 1; imm = 32'h2;
    fetch_q.delete();
    tick();
    clear_ctrl();
    repeat (6) tick();
`ifdef MISALIGN_TRAP_EN
    chk("trap_fault", fetch_fault, 1);
    chk("trap_pc", pc_o, 32'h8);
    chk("trap_req", imem_req, 0);
    chk("trap_nfetch", fetch_q.size(), 0);
`else
    chk("align_addr", fetch_q[0], 32'h8);
    chk("align_fault", fetch_fault, 0);
`endif

    // Randomized traffic with spurious gnt/rvalid and random decode stalls.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      imem_gnt    = ($urandom % 2) == 0;
      imem_rvalid = ($urandom % 3) != 0;
      imem_rdata  = $urandom;
      instr_ready = ($urandom % 4) != 0;
      branch = $urandom; bne = $urandom; jal = ($urandom % 4) == 0;
      jalr = ($urandom % 4) == 0; alu_zero = $urandom;
      imm = $urandom & 32'hFFFF_FFFC;
      rs1_data = $urandom & 32'hFFFF_FFFD;
      rst_n = ($urandom % 500) != 0;
      tick();
    end
    rst_n = 1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1);
  end

endmodule
